// File: rtl/pm_pkg.sv
// Shared definitions for the program-memory boot responder: boot FSM state
// encoding, the fetch NOP word and the header length.
package pm_pkg;

    typedef enum logic [2:0] {
        ST_HDR0 = 3'd0,
        ST_HDR1 = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } pm_state_e;

    localparam logic [31:0] PM_NOP       = 32'h0;
    localparam int          PM_HDR_BYTES = 2;

endpackage

// File: rtl/pm_mem_arr.sv
// Single-port program memory: synchronous write from the boot loader,
// combinational read that the fetch path registers. Contents are never reset.
module pm_mem_arr #(
    parameter int PM_AW = 8
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PM_AW-1:0] i_addr,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [2**PM_AW];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/pm_boot_rspndr.sv
// Boot responder: loads a length-prefixed little-endian word stream into
// program memory, then serves sequencer fetches. Define PM_BT_CHKSUM_EN to
// require a trailing 32-bit sum of the loaded words before releasing the core.
module pm_boot_rspndr
    import pm_pkg::*;
#(
    parameter int PM_AW = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps_pm_cslt,
    input  logic        ps_pm_wrb,
    input  logic [15:0] ps_pm_add,
    output logic [31:0] pm_ps_op,
    input  logic        bt_vld,
    input  logic [7:0]  bt_dt,
    output logic        bt_rdy,
    output logic        pm_ps_rst,
    output logic        pm_bt_done,
    output logic        pm_bt_err
);

    localparam logic [16:0] DEPTH = 17'd1 << PM_AW;

    pm_state_e   r_state;
    logic [15:0] r_n;
    logic [16:0] r_wadr;
    logic [1:0]  r_bcnt;
    logic [23:0] r_word;
    logic [31:0] r_op;
    logic        r_ps_rst;
`ifdef PM_BT_CHKSUM_EN
    logic [31:0] r_acc;
`endif

    logic [15:0]      w_hdr_n;
    logic [31:0]      w_full;
    logic             w_last;
    logic             w_we;
    logic             w_oor;
    logic [PM_AW-1:0] w_addr;
    logic [31:0]      w_rdata;

    assign w_hdr_n = {bt_dt, r_n[7:0]};
    assign w_full  = {bt_dt, r_word};
    assign w_last  = (r_wadr + 17'd1) == {1'b0, r_n};
    assign w_we    = (r_state == ST_DATA) && bt_vld && (r_bcnt == 2'd3);
    assign w_oor   = {1'b0, ps_pm_add} >= DEPTH;
    // Single port: the loader owns the address until RUN, the sequencer after.
    assign w_addr  = (r_state == ST_RUN) ? ps_pm_add[PM_AW-1:0] : r_wadr[PM_AW-1:0];

    pm_mem_arr #(.PM_AW(PM_AW)) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_full),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_HDR0;
            r_n      <= '0;
            r_wadr   <= '0;
            r_bcnt   <= '0;
            r_word   <= '0;
            r_ps_rst <= 1'b0;
`ifdef PM_BT_CHKSUM_EN
            r_acc    <= '0;
`endif
        end else begin
            r_ps_rst <= (r_state == ST_RUN);
            case (r_state)
                ST_HDR0: if (bt_vld) begin
                    r_n[7:0] <= bt_dt;
                    r_state  <= ST_HDR1;
                end
                ST_HDR1: if (bt_vld) begin
                    r_n[15:8] <= bt_dt;
                    if ({1'b0, w_hdr_n} > DEPTH)
                        r_state <= ST_ERR;
                    else if (w_hdr_n == 16'd0)
`ifdef PM_BT_CHKSUM_EN
                        r_state <= ST_CHK;
`else
                        r_state <= ST_RUN;
`endif
                    else
                        r_state <= ST_DATA;
                end
                ST_DATA: if (bt_vld) begin
                    r_bcnt <= r_bcnt + 2'd1;
                    case (r_bcnt)
                        2'd0: r_word[7:0]   <= bt_dt;
                        2'd1: r_word[15:8]  <= bt_dt;
                        2'd2: r_word[23:16] <= bt_dt;
                        default: begin
                            r_wadr <= r_wadr + 17'd1;
`ifdef PM_BT_CHKSUM_EN
                            r_acc  <= r_acc + w_full;
                            if (w_last) r_state <= ST_CHK;
`else
                            if (w_last) r_state <= ST_RUN;
`endif
                        end
                    endcase
                end
`ifdef PM_BT_CHKSUM_EN
                ST_CHK: if (bt_vld) begin
                    r_bcnt <= r_bcnt + 2'd1;
                    case (r_bcnt)
                        2'd0: r_word[7:0]   <= bt_dt;
                        2'd1: r_word[15:8]  <= bt_dt;
                        2'd2: r_word[23:16] <= bt_dt;
                        default: r_state <= (w_full == r_acc) ? ST_RUN : ST_ERR;
                    endcase
                end
`endif
                default: ;
            endcase
        end
    end

    // Idle sequencer (cslt=0) keeps seeing the last op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_op <= PM_NOP;
        else if (r_state != ST_RUN)
            r_op <= PM_NOP;
        else if (ps_pm_cslt)
            r_op <= (ps_pm_wrb || w_oor) ? PM_NOP : w_rdata;
    end

    assign pm_ps_op   = r_op;
    assign pm_ps_rst  = r_ps_rst;
    assign pm_bt_done = (r_state == ST_RUN);
    assign bt_rdy     = (r_state != ST_RUN) && (r_state != ST_ERR);
`ifdef PM_BT_CHKSUM_EN
    assign pm_bt_err  = (r_state == ST_ERR);
`else
    assign pm_bt_err  = 1'b0;
`endif

endmodule

// File: tb/tb_pm_boot_rspndr.sv
// Directed bench for pm_boot_rspndr: load, fetch, error and mid-boot reset
// scenarios; checksum scenarios follow PM_BT_CHKSUM_EN.
module tb_pm_boot_rspndr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps_pm_cslt = 1'b0;
    logic        ps_pm_wrb = 1'b0;
    logic [15:0] ps_pm_add = '0;
    logic [31:0] pm_ps_op;
    logic        bt_vld = 1'b0;
    logic [7:0]  bt_dt = '0;
    logic        bt_rdy;
    logic        pm_ps_rst;
    logic        pm_bt_done;
    logic        pm_bt_err;

    int n_chk = 0;
    int n_err = 0;

`ifdef PM_BT_CHKSUM_EN
    localparam logic CK = 1'b1;
`else
    localparam logic CK = 1'b0;
`endif

    pm_boot_rspndr #(.PM_AW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps_pm_cslt (ps_pm_cslt),
        .ps_pm_wrb  (ps_pm_wrb),
        .ps_pm_add  (ps_pm_add),
        .pm_ps_op   (pm_ps_op),
        .bt_vld     (bt_vld),
        .bt_dt      (bt_dt),
        .bt_rdy     (bt_rdy),
        .pm_ps_rst  (pm_ps_rst),
        .pm_bt_done (pm_bt_done),
        .pm_bt_err  (pm_bt_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bt_vld = 1'b1;
        bt_dt  = b;
        @(posedge clk);
        #1 bt_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Standard two-word image; checksum bytes appended when enabled.
    task automatic load_std(input logic [31:0] sum);
        send(8'h02); send(8'h00);
        send(8'h11); send(8'h22); idle(1); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66); send(8'h77); send(8'h88);
        if (CK) begin
            send(sum[7:0]); send(sum[15:8]); send(sum[23:16]); send(sum[31:24]);
        end
    endtask

    task automatic fetch(input logic [15:0] a, input logic wr);
        @(negedge clk);
        ps_pm_cslt = 1'b1;
        ps_pm_wrb  = wr;
        ps_pm_add  = a;
        @(negedge clk);
        ps_pm_cslt = 1'b0;
        ps_pm_wrb  = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_op", pm_ps_op, 32'h0);
        check("rst_psrst", {31'b0, pm_ps_rst}, 32'h0);
        check("rst_done", {31'b0, pm_bt_done}, 32'h0);
        check("rst_err", {31'b0, pm_bt_err}, 32'h0);
        check("rst_rdy", {31'b0, bt_rdy}, 32'h1);
        @(negedge clk);
        rst = 1'b1;

        // Standard load -> RUN, pm_ps_rst one cycle behind done
        load_std(32'hCCAA8866);
        @(negedge clk);
        check("ld_done", {31'b0, pm_bt_done}, 32'h1);
        check("ld_psrst_lag", {31'b0, pm_ps_rst}, 32'h0);
        check("ld_rdy_run", {31'b0, bt_rdy}, 32'h0);
        @(negedge clk);
        check("ld_psrst", {31'b0, pm_ps_rst}, 32'h1);
        check("ld_err", {31'b0, pm_bt_err}, 32'h0);

        // Fetch with 1-cycle latency, then hold while cslt=0
        fetch(16'h0001, 1'b0);
        check("fetch1", pm_ps_op, 32'h88776655);
        @(negedge clk);
        check("fetch1_hold", pm_ps_op, 32'h88776655);
        fetch(16'h0000, 1'b0);
        check("fetch0", pm_ps_op, 32'h44332211);
        fetch(16'h0100, 1'b0);
        check("fetch_oor", pm_ps_op, 32'h0);
        fetch(16'h0000, 1'b1);
        check("fetch_wr", pm_ps_op, 32'h0);
        fetch(16'h0000, 1'b0);
        check("fetch0_after_wr", pm_ps_op, 32'h44332211);

        // Oversize header goes straight to ERR
        do_reset();
        send(8'h01); send(8'h01);
        @(negedge clk);
        check("big_rdy", {31'b0, bt_rdy}, 32'h0);
        check("big_done", {31'b0, pm_bt_done}, 32'h0);
        check("big_err", {31'b0, pm_bt_err}, {31'b0, CK});
        fetch(16'h0001, 1'b0);
        check("big_op", pm_ps_op, 32'h0);
        check("big_psrst", {31'b0, pm_ps_rst}, 32'h0);

`ifdef PM_BT_CHKSUM_EN
        // Bad checksum -> ERR
        do_reset();
        load_std(32'h0);
        @(negedge clk);
        @(negedge clk);
        check("ck_bad_err", {31'b0, pm_bt_err}, 32'h1);
        check("ck_bad_psrst", {31'b0, pm_ps_rst}, 32'h0);
        check("ck_bad_rdy", {31'b0, bt_rdy}, 32'h0);
        check("ck_bad_done", {31'b0, pm_bt_done}, 32'h0);
`endif

        // Mid-boot async reset with a stalling source, then reload
        do_reset();
        send(8'h02); send(8'h00);
        send(8'hA1); idle(1); send(8'hA2); idle(2); send(8'hA3);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_op", pm_ps_op, 32'h0);
        check("mid_done", {31'b0, pm_bt_done}, 32'h0);
        check("mid_psrst", {31'b0, pm_ps_rst}, 32'h0);
        check("mid_rdy", {31'b0, bt_rdy}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        send(8'h01); send(8'h00);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        if (CK) begin
            send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        end
        @(negedge clk);
        check("re_done", {31'b0, pm_bt_done}, 32'h1);
        fetch(16'h0000, 1'b0);
        check("re_fetch0", pm_ps_op, 32'hEFBEADDE);
        check("re_psrst", {31'b0, pm_ps_rst}, 32'h1);
        fetch(16'h0001, 1'b0);
        check("re_fetch1_kept", pm_ps_op, 32'h88776655);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
